// File: rtl/zigzag_reorder_pkg.sv
// Shared types and constants for the zigzag reorder buffer.
// The zigzag table maps a scan position (0..63) to the raster index
// of the coefficient emitted at that position.
package zigzag_reorder_pkg;

    localparam int JPEG_BLK_SIZE  = 8;
    localparam int JPEG_BLK_ELEMS = JPEG_BLK_SIZE * JPEG_BLK_SIZE;
    localparam int BLK_ADDR_WIDTH = 6;

    typedef logic [BLK_ADDR_WIDTH-1:0] blk_idx_t;

    localparam blk_idx_t BLK_LAST = blk_idx_t'(JPEG_BLK_ELEMS - 1);

    typedef enum logic [0:0] {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_t;

    localparam blk_idx_t ZIGZAG_LUT [JPEG_BLK_ELEMS] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic blk_idx_t zigzag_addr(input blk_idx_t scan_idx);
        return ZIGZAG_LUT[scan_idx];
    endfunction

    function automatic bank_t other_bank(input bank_t bank);
        return (bank == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/zigzag_reorder_if.sv
// AXI4-Stream style link used on both sides of the zigzag reorder buffer.
// Only the subset tdata/tvalid/tready/tlast is carried.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 16
);

    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/zigzag_reorder_ram.sv
// Simple dual-port block RAM: one write port, one read port, registered
// read data (one clock of read latency). Contents are not reset.
module dual_port_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word when the write port is enabled.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register the addressed word so read data appears one clock later.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: coefficients arrive in raster order, are
// written into one of two RAM banks, and are read back in JPEG zigzag order
// through a two-entry output FIFO. Writing block n+1 overlaps reading block n.
module zigzag_reorder
    import zigzag_reorder_pkg::*;
#(
    parameter int PX_WIDTH    = 12,
    parameter int TDATA_WIDTH = 16,
    parameter int MAT_SIZE    = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o,
    output logic         sync_err_o
);

    if (MAT_SIZE != JPEG_BLK_SIZE) begin : g_bad_mat_size
        $error("zigzag_reorder: MAT_SIZE must be 8, the zigzag table is fixed at 8x8");
    end

    if (TDATA_WIDTH < PX_WIDTH) begin : g_bad_tdata_width
        $error("zigzag_reorder: TDATA_WIDTH must be at least PX_WIDTH");
    end

    // Write side state
    blk_idx_t wr_cnt;
    bank_t    wr_bank;
    logic     ready_en;
    logic     wr_fire;
    logic     wr_block_end;

    // Bank occupancy, one flag per bank
    logic [1:0] bank_full;

    // Read side state
    blk_idx_t rd_cnt;
    bank_t    rd_bank;
    bank_t    rd_bank_q;
    logic     rd_pending;
    logic     rd_last_q;
    logic     rd_issue;
    logic     rd_block_end;
    blk_idx_t rd_addr;

    // RAM ports
    logic                wr_en_bank0;
    logic                wr_en_bank1;
    logic                rd_en_bank0;
    logic                rd_en_bank1;
    logic [PX_WIDTH-1:0] wr_data;
    logic [PX_WIDTH-1:0] rd_data_bank0;
    logic [PX_WIDTH-1:0] rd_data_bank1;
    logic [PX_WIDTH-1:0] rd_word;

    // Output FIFO; entry 0 is always the head
    logic [PX_WIDTH-1:0] fifo_data [2];
    logic [1:0]          fifo_last;
    logic [1:0]          fifo_count;
    logic                fifo_pop;
    logic [2:0]          fifo_occ_next;

    if (TDATA_WIDTH > PX_WIDTH) begin : g_unused_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^video_i.tdata[TDATA_WIDTH-1:PX_WIDTH];
    end

    assign video_i.tready = ready_en && !bank_full[wr_bank];
    assign wr_fire        = rst_n_i && video_i.tvalid && video_i.tready;
    assign wr_block_end   = wr_fire && (wr_cnt == BLK_LAST);
    assign wr_data        = video_i.tdata[PX_WIDTH-1:0];
    assign wr_en_bank0    = wr_fire && (wr_bank == BANK_0);
    assign wr_en_bank1    = wr_fire && (wr_bank == BANK_1);

    assign fifo_pop       = video_o.tvalid && video_o.tready;
    assign rd_block_end   = rd_issue && (rd_cnt == BLK_LAST);
    assign rd_addr        = zigzag_addr(rd_cnt);
    assign rd_en_bank0    = rd_issue && (rd_bank == BANK_0);
    assign rd_en_bank1    = rd_issue && (rd_bank == BANK_1);
    assign rd_word        = (rd_bank_q == BANK_0) ? rd_data_bank0 : rd_data_bank1;

    assign video_o.tvalid = (fifo_count != 2'd0);
    assign video_o.tdata  = TDATA_WIDTH'(fifo_data[0]);
    assign video_o.tlast  = fifo_last[0];

    // Issue a read only if the FIFO, after this clock's pop and the pending
    // read's push, still has room; counting the pop keeps 1 beat/clk flowing.
    always_comb begin
        fifo_occ_next = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, fifo_pop};
        rd_issue      = rst_n_i && bank_full[rd_bank] && (fifo_occ_next < 3'd2);
    end

    // Write counter, write bank, input ready enable and block-alignment check.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_cnt     <= '0;
            wr_bank    <= BANK_0;
            ready_en   <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            sync_err_o <= wr_fire && (video_i.tlast != (wr_cnt == BLK_LAST));
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == BLK_LAST) begin
                    wr_bank <= other_bank(wr_bank);
                end
            end
        end
    end

    // Bank flags: the writer sets its bank, the reader clears its bank; the
    // two never target the same bank in one clock because of ping-pong order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bank_full <= 2'b00;
        end else begin
            if (wr_block_end) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (rd_block_end) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read scan counter, read bank and the one-deep in-flight read tracker.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_cnt     <= '0;
            rd_bank    <= BANK_0;
            rd_bank_q  <= BANK_0;
            rd_pending <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_bank_q <= rd_bank;
                rd_last_q <= (rd_cnt == BLK_LAST);
                rd_cnt    <= rd_cnt + 1'b1;
                if (rd_cnt == BLK_LAST) begin
                    rd_bank <= other_bank(rd_bank);
                end
            end
        end
    end

    // Two-entry output FIFO fed by returning RAM reads, drained by video_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fifo_count <= 2'd0;
            fifo_last  <= 2'b00;
        end else begin
            case ({rd_pending, fifo_pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        fifo_data[0] <= rd_word;
                        fifo_last[0] <= rd_last_q;
                    end else begin
                        fifo_data[1] <= rd_word;
                        fifo_last[1] <= rd_last_q;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_data[0] <= fifo_data[1];
                    fifo_last[0] <= fifo_last[1];
                    fifo_count   <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_data[0] <= rd_word;
                        fifo_last[0] <= rd_last_q;
                    end else begin
                        fifo_data[0] <= fifo_data[1];
                        fifo_last[0] <= fifo_last[1];
                        fifo_data[1] <= rd_word;
                        fifo_last[1] <= rd_last_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dual_port_ram #(
        .DATA_WIDTH (PX_WIDTH),
        .ADDR_WIDTH (BLK_ADDR_WIDTH)
    ) u_ram_bank0 (
        .clk_i   (clk_i),
        .wr_en   (wr_en_bank0),
        .wr_addr (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (rd_en_bank0),
        .rd_addr (rd_addr),
        .rd_data (rd_data_bank0)
    );

    dual_port_ram #(
        .DATA_WIDTH (PX_WIDTH),
        .ADDR_WIDTH (BLK_ADDR_WIDTH)
    ) u_ram_bank1 (
        .clk_i   (clk_i),
        .wr_en   (wr_en_bank1),
        .wr_addr (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (rd_en_bank1),
        .rd_addr (rd_addr),
        .rd_data (rd_data_bank1)
    );

endmodule

// File: tb/tb_zigzag_reorder.sv
// Testbench for zigzag_reorder: directed steps drive raster-order blocks,
// a scoreboard holds the expected zigzag stream built from an independent
// diagonal-walk model, and a monitor compares every output beat.
module tb_zigzag_reorder;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t        sb[$];
    int          zz[64];
    logic [11:0] blk_buf[64];
    int          blk_idx = 0;

    int out_mode = 1;
    int first_valid_cyc = -1;
    int last_hs_cyc = 0;
    int sync_pulses = 0;
    int in_stalls = 0;
    int out_beats = 0;

    axi4_stream_if #(.TDATA_WIDTH(16)) video_in ();
    axi4_stream_if #(.TDATA_WIDTH(16)) video_out ();

    zigzag_reorder #(
        .PX_WIDTH    (12),
        .TDATA_WIDTH (16),
        .MAT_SIZE    (8)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .video_i    (video_in),
        .video_o    (video_out),
        .sync_err_o (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one beat starting at posedge+1, waits for tready within a bound,
    // records the beat in the block model and pushes a finished block in zigzag order.
    task automatic applyStimulus(input logic [11:0] d, input logic last, input int gap,
                                 input int limit, output bit accepted, output int hs_cyc);
        int waited;
        repeat (gap) begin
            video_in.tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        video_in.tdata  = {4'h0, d};
        video_in.tlast  = last;
        video_in.tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!video_in.tready && waited < limit) begin
            in_stalls++;
            @(negedge clk);
            waited++;
        end
        accepted = video_in.tready;
        hs_cyc   = cyc;
        if (accepted) begin
            blk_buf[blk_idx] = d;
            if (blk_idx == 63) begin
                for (int k = 0; k < 64; k++) begin
                    sb.push_back('{data: {4'h0, blk_buf[zz[k]]}, last: (k == 63)});
                end
            end
            blk_idx = (blk_idx + 1) % 64;
        end
        @(posedge clk);
        #1;
        video_in.tvalid = 1'b0;
        video_in.tlast  = 1'b0;
    endtask

    task automatic sendBlock(input int pattern, input int base, input bit rand_gap, input int tlast_pos);
        bit acc;
        int hc;
        for (int i = 0; i < 64; i++) begin
            logic [11:0] d;
            case (pattern)
                0:       d = 12'(i);
                1:       d = 12'($urandom);
                default: d = 12'(base + i);
            endcase
            applyStimulus(d, (i == tlast_pos), rand_gap ? int'($urandom_range(0, 1)) : 0, 1000, acc, hc);
            checkOutput("in_accept", 32'(acc), 32'd1);
            last_hs_cyc = hc;
        end
    endtask

    task automatic waitDrain(input string tag, input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || video_out.tvalid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(n < limit), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Output ready pattern: held low, held high or 50% random.
    initial begin
        video_out.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       video_out.tready = 1'b0;
                1:       video_out.tready = 1'b1;
                default: video_out.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks holds.
    initial begin
        logic        hold_prev;
        logic [15:0] hold_data;
        logic        hold_last;
        hold_prev = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (sync_err) sync_pulses++;
                if (video_out.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (hold_prev) begin
                    checkOutput("hold_tvalid", 32'(video_out.tvalid), 32'd1);
                    checkOutput("hold_tdata", 32'(video_out.tdata), 32'(hold_data));
                    checkOutput("hold_tlast", 32'(video_out.tlast), 32'(hold_last));
                end
                if (video_out.tvalid && video_out.tready) begin
                    exp_t e;
                    checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        checkOutput("out_tdata", 32'(video_out.tdata), 32'(e.data));
                        checkOutput("out_tlast", 32'(video_out.tlast), 32'(e.last));
                    end
                    out_beats++;
                end
                hold_prev = video_out.tvalid && !video_out.tready;
                hold_data = video_out.tdata;
                hold_last = video_out.tlast;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  r;
        int  c;
        int  beats0;
        int  acc_cnt;
        bit  acc;
        int  hc;

        // Reference zigzag order by walking the anti-diagonals of an 8x8 grid.
        r = 0;
        c = 0;
        for (int k = 0; k < 64; k++) begin
            zz[k] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7)      r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7)      c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end

        video_in.tdata  = '0;
        video_in.tvalid = 1'b0;
        video_in.tlast  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_tvalid", 32'(video_out.tvalid), 32'd0);
        checkOutput("reset_sync_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        checkOutput("reset_tready", 32'(video_in.tready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: one raster-index block, latency of first output beat
        $display("[TB] test 1: single block");
        out_mode = 1;
        first_valid_cyc = -1;
        sendBlock(0, 0, 1'b0, 63);
        waitDrain("t1_drain", 500);
        checkOutput("t1_latency", 32'(first_valid_cyc - last_hs_cyc), 32'd3);

        // Test 2: four back-to-back blocks with both sides always ready
        $display("[TB] test 2: four blocks back-to-back");
        in_stalls = 0;
        sync_pulses = 0;
        beats0 = out_beats;
        for (int b = 0; b < 4; b++) sendBlock(2, 100 * b, 1'b0, 63);
        waitDrain("t2_drain", 500);
        checkOutput("t2_in_stalls", 32'(in_stalls), 32'd0);
        checkOutput("t2_sync_pulses", 32'(sync_pulses), 32'd0);
        checkOutput("t2_out_beats", 32'(out_beats - beats0), 32'd256);

        // Test 3: output held off, input fills both banks then stalls
        $display("[TB] test 3: output backpressure");
        out_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        beats0 = out_beats;
        acc_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(12'($urandom), (blk_idx == 63), 0, 170, acc, hc);
            if (!acc) break;
            acc_cnt++;
        end
        checkOutput("t3_accepted", 32'(acc_cnt), 32'd128);
        checkOutput("t3_tready_low", 32'(video_in.tready), 32'd0);
        checkOutput("t3_no_output", 32'(out_beats - beats0), 32'd0);
        out_mode = 1;
        waitDrain("t3_drain", 500);
        checkOutput("t3_out_beats", 32'(out_beats - beats0), 32'd128);

        // Test 4: random valid/ready on both sides, random data
        $display("[TB] test 4: random traffic");
        out_mode = 2;
        beats0 = out_beats;
        for (int b = 0; b < 200; b++) sendBlock(1, 0, 1'b1, 63);
        waitDrain("t4_drain", 2000);
        checkOutput("t4_out_beats", 32'(out_beats - beats0), 32'd12800);

        // Test 5: misplaced input tlast
        $display("[TB] test 5: tlast misalignment");
        out_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        sync_pulses = 0;
        sendBlock(1, 0, 1'b0, 9);
        waitDrain("t5_drain", 500);
        checkOutput("t5_sync_pulses", 32'(sync_pulses), 32'd2);

        // Test 6: reset mid-stream, then a clean block
        $display("[TB] test 6: reset mid-stream");
        beats0 = out_beats;
        sendBlock(1, 0, 1'b0, 63);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(12'($urandom), 1'b0, 0, 1000, acc, hc);
            checkOutput("t6_in_accept", 32'(acc), 32'd1);
        end
        checkOutput("t6_mid_block", 32'((out_beats - beats0) > 0 && (out_beats - beats0) < 64), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        blk_idx = 0;
        @(negedge clk);
        checkOutput("t6_tvalid_after_reset", 32'(video_out.tvalid), 32'd0);
        @(negedge clk);
        checkOutput("t6_tready_after_reset", 32'(video_in.tready), 32'd1);
        checkOutput("t6_tvalid_idle", 32'(video_out.tvalid), 32'd0);
        @(posedge clk);
        #1;
        beats0 = out_beats;
        sendBlock(1, 0, 1'b0, 63);
        waitDrain("t6_drain", 500);
        checkOutput("t6_out_beats", 32'(out_beats - beats0), 32'd64);

        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
